bp_me_mem_cmd_arbiter: RTL and testbench

Upstream neighbour of the L2 cache adapter. It merges BedRock memory command streams from num_src_p sources (e.g. CCE and I/O master) into the adapter's single command port, using round-robin arbitration. A source-ID FIFO routes the adapter's in-order responses back to the requester that issued each command.

---
 rtl/bp_me_mem_cmd_arbiter_if.sv | 34 +++
 rtl/bp_me_mem_cmd_arbiter.sv | 92 +++++++++
 tb/tb_bp_me_mem_cmd_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bp_me_mem_cmd_arbiter_if.sv
// bp_me_mem_cmd_arbiter_if: command/response bundle between the sources, the arbiter and the L2 adapter
interface bp_me_mem_cmd_arbiter_if #(
  parameter int num_src_p     = 2,
  parameter int msg_width_p   = 64,
  parameter int outstanding_p = 4,
  localparam int cnt_width_lp = (outstanding_p > 0) ? $clog2(outstanding_p + 1) : 1
);
  logic [num_src_p*msg_width_p-1:0] mem_cmd_i;
  logic [num_src_p-1:0]             mem_cmd_v_i;
  logic [num_src_p-1:0]             mem_cmd_ready_o;
  logic [msg_width_p-1:0]           mem_cmd_o;
  logic                             mem_cmd_v_o;
  logic                             mem_cmd_ready_i;
  logic [msg_width_p-1:0]           mem_resp_i;
  logic                             mem_resp_v_i;
  logic                             mem_resp_yumi_o;
  logic [msg_width_p-1:0]           mem_resp_o;
  logic [num_src_p-1:0]             mem_resp_v_o;
  logic [num_src_p-1:0]             mem_resp_yumi_i;
  logic [cnt_width_lp-1:0]          outstanding_o;
  logic                             error_o;

  modport master (
    input  mem_cmd_i, mem_cmd_v_i, mem_cmd_ready_i, mem_resp_i, mem_resp_v_i, mem_resp_yumi_i,
    output mem_cmd_ready_o, mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o, mem_resp_o, mem_resp_v_o,
           outstanding_o, error_o
  );

  modport slave (
    output mem_cmd_i, mem_cmd_v_i, mem_cmd_ready_i, mem_resp_i, mem_resp_v_i, mem_resp_yumi_i,
    input  mem_cmd_ready_o, mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o, mem_resp_o, mem_resp_v_o,
           outstanding_o, error_o
  );
endinterface

// File: rtl/bp_me_mem_cmd_arbiter.sv
// bp_me_mem_cmd_arbiter: round-robin merge of command streams with in-order response routing
module bp_me_mem_cmd_arbiter #(
  parameter int num_src_p     = 2,
  parameter int msg_width_p   = 64,
  parameter int outstanding_p = 4,
  localparam int lg_src_lp    = (num_src_p > 1) ? $clog2(num_src_p) : 1,
  localparam int cnt_width_lp = (outstanding_p > 0) ? $clog2(outstanding_p + 1) : 1,
  localparam int lg_out_lp    = (outstanding_p > 1) ? $clog2(outstanding_p) : 1
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bp_me_mem_cmd_arbiter_if.master bus
);
  logic [1:0]              sync_q, sync_d;
  logic [lg_src_lp-1:0]    ptr_q, ptr_d, lock_src_q, lock_src_d;
  logic                    lock_q, lock_d, err_q, err_d;
  logic [lg_src_lp-1:0]    fifo_q [outstanding_p];
  logic [lg_src_lp-1:0]    fifo_d [outstanding_p];
  logic [lg_out_lp-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic [lg_src_lp-1:0]    g_rr, g, h;
  logic                    active, full, empty, push, pop;

  function automatic logic [lg_src_lp-1:0] wrap_src(input int x);
    return lg_src_lp'((x >= num_src_p) ? x - num_src_p : x);
  endfunction

  function automatic logic [lg_out_lp-1:0] next_slot(input logic [lg_out_lp-1:0] p);
    return (p == lg_out_lp'(outstanding_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // grant selection and all handshake outputs; everything is held off until reset release has synchronised
  always_comb begin
    active = sync_q[1];
    g_rr = ptr_q;
    for (int i = num_src_p - 1; i >= 0; i--)
      if (bus.mem_cmd_v_i[wrap_src(int'(ptr_q) + i)]) g_rr = wrap_src(int'(ptr_q) + i);
    g = lock_q ? lock_src_q : g_rr;
    h = fifo_q[rptr_q];
    full = cnt_q == cnt_width_lp'(outstanding_p);
    empty = cnt_q == '0;
    bus.mem_cmd_o = bus.mem_cmd_i[g*msg_width_p +: msg_width_p];
    bus.mem_cmd_v_o = active & (|bus.mem_cmd_v_i) & ~full;
    bus.mem_cmd_ready_o = (active & bus.mem_cmd_ready_i & ~full) ? num_src_p'(1) << g : '0;
    bus.mem_resp_o = bus.mem_resp_i;
    bus.mem_resp_v_o = (active & bus.mem_resp_v_i & ~empty) ? num_src_p'(1) << h : '0;
    bus.mem_resp_yumi_o = active & ~empty & bus.mem_resp_yumi_i[h];
    bus.outstanding_o = cnt_q;
    bus.error_o = err_q;
    push = bus.mem_cmd_v_o & bus.mem_cmd_ready_i;
    pop = bus.mem_resp_yumi_o;
  end

  // next state: source-ID FIFO, round-robin pointer, grant lock while the adapter stalls, sticky error
  always_comb begin
    sync_d = {sync_q[0], 1'b1};
    fifo_d = fifo_q;
    if (push) fifo_d[wptr_q] = g;
    wptr_d = push ? next_slot(wptr_q) : wptr_q;
    rptr_d = pop ? next_slot(rptr_q) : rptr_q;
    cnt_d = cnt_q + cnt_width_lp'(push) - cnt_width_lp'(pop);
    ptr_d = push ? wrap_src(int'(g) + 1) : ptr_q;
    lock_d = bus.mem_cmd_v_o ? ~bus.mem_cmd_ready_i : lock_q;
    lock_src_d = (bus.mem_cmd_v_o & ~bus.mem_cmd_ready_i) ? g : lock_src_q;
    err_d = err_q | (active & bus.mem_resp_v_i & empty);
  end

  // state registers; reset asserts asynchronously and its release walks through a 2-flop synchroniser
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q     <= '0;
      fifo_q     <= '{default: '0};
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_src_q <= '0;
      err_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// tb_bp_me_mem_cmd_arbiter: randomized and directed checks against a queue-based reference model
module tb_bp_me_mem_cmd_arbiter;
  localparam int N = 2, W = 64, OUT = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_me_mem_cmd_arbiter_if #(.num_src_p(N), .msg_width_p(W), .outstanding_p(OUT)) bus ();
  bp_me_mem_cmd_arbiter #(.num_src_p(N), .msg_width_p(W), .outstanding_p(OUT)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus)
  );

  int n_chk = 0, n_fail = 0;
  bit [N-1:0] pend, ym;
  bit rdy, rv;
  logic [W-1:0] dat [N];
  logic [W-1:0] rdat;
  int ptr, lock_src, act;
  bit lock, err;
  int q[$];

  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    ptr = 0; lock = 0; lock_src = 0; act = 0; err = 0; q.delete();
  endtask

  task automatic cycle();
    bit on, full, empty, found, x_v, x_y;
    bit [N-1:0] x_rdy, x_rv;
    int g, h;
    bus.mem_cmd_v_i = pend;
    bus.mem_cmd_i = {dat[1], dat[0]};
    bus.mem_cmd_ready_i = rdy;
    bus.mem_resp_v_i = rv;
    bus.mem_resp_i = rdat;
    bus.mem_resp_yumi_i = ym;
    @(negedge clk);
    on = act >= 2;
    full = q.size() == OUT;
    empty = q.size() == 0;
    g = ptr;
    found = 0;
    if (lock) g = lock_src;
    else
      for (int i = 0; i < N; i++)
        if (!found && pend[(ptr + i) % N]) begin g = (ptr + i) % N; found = 1; end
    x_v = on && pend != 0 && !full;
    x_rdy = 0;
    if (on && rdy && !full) x_rdy[g] = 1;
    h = empty ? 0 : q[0];
    x_rv = 0;
    if (on && rv && !empty) x_rv[h] = 1;
    x_y = on && !empty && ym[h];
    chk("cmd_v", bus.mem_cmd_v_o, x_v);
    chk("cmd_ready", bus.mem_cmd_ready_o, x_rdy);
    if (x_v) chk("cmd_data", bus.mem_cmd_o, dat[g]);
    chk("resp_v", bus.mem_resp_v_o, x_rv);
    chk("resp_yumi", bus.mem_resp_yumi_o, x_y);
    chk("resp_data", bus.mem_resp_o, rdat);
    chk("outstanding", bus.outstanding_o, q.size());
    chk("error", bus.error_o, err);
    @(posedge clk);
    if (on) begin
      if (x_y) void'(q.pop_front());
      if (x_v && rdy) begin
        q.push_back(g); ptr = (g + 1) % N; lock = 0; pend[g] = 0;
      end else if (x_v) begin
        lock = 1; lock_src = g;
      end
      if (rv && empty) err = 1;
    end
    if (rst_n && act < 2) act++;
    #1;
  endtask

  task automatic new_cmds();
    for (int s = 0; s < N; s++)
      if (!pend[s]) begin pend[s] = 1; dat[s] = {$urandom, $urandom}; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    pend = 0; ym = 0; rdy = 0; rv = 0; rdat = 0; dat[0] = 0; dat[1] = 0;
    mreset();
    repeat (2) cycle();
    rst_n = 1;
    pend = 2'b01; dat[0] = 64'h8000_0000; rdy = 1;
    repeat (3) cycle();
    chk("t1_out_after_cmd", bus.outstanding_o, 1);
    rv = 1; ym = 2'b01; rdat = {$urandom, $urandom};
    cycle();
    chk("t1_out_after_resp", bus.outstanding_o, 0);
    rv = 0; ym = 0;
    for (int i = 0; i < 8; i++) begin
      new_cmds(); rv = q.size() > 0; ym = 2'b11; rdat = {$urandom, $urandom};
      cycle();
    end
    pend = 0; rdy = 0;
    while (q.size() > 0) begin rv = 1; ym = 2'b11; cycle(); end
    rv = 1; ym = 2'b01;
    cycle();
    chk("err_set", bus.error_o, 1);
    rv = 0; ym = 0;
    cycle();
    chk("err_sticky", bus.error_o, 1);
    rdy = 1;
    repeat (6) begin new_cmds(); cycle(); end
    chk("full_v", bus.mem_cmd_v_o, 0);
    chk("full_ready", bus.mem_cmd_ready_o, 0);
    chk("full_out", bus.outstanding_o, 4);
    rv = 1; ym = 2'b11;
    cycle();
    chk("full_pop", bus.outstanding_o, 3);
    rv = 0; ym = 0;
    cycle();
    chk("full_resume", bus.outstanding_o, 4);
    rdy = 0; rv = 1; ym = 2'b11;
    cycle();
    chk("pre_reset_out", bus.outstanding_o, 3);
    #2 rst_n = 0;
    #1 mreset();
    pend = 0; rv = 0; ym = 0;
    chk("rst_cmd_v", bus.mem_cmd_v_o, 0);
    chk("rst_ready", bus.mem_cmd_ready_o, 0);
    chk("rst_out", bus.outstanding_o, 0);
    chk("rst_err", bus.error_o, 0);
    cycle();
    rst_n = 1;
    repeat (2) cycle();
    pend = 2'b10; dat[1] = 64'hAAAA_0001_AAAA_0001;
    cycle();
    pend = 2'b11; dat[0] = 64'hBBBB_0000_BBBB_0000;
    repeat (2) cycle();
    chk("lock_hold", bus.mem_cmd_o, 64'hAAAA_0001_AAAA_0001);
    rdy = 1;
    cycle();
    cycle();
    chk("lock_out", bus.outstanding_o, 2);
    pend = 2'b01; dat[0] = {$urandom, $urandom}; rv = 1; ym = 2'b11;
    cycle();
    chk("push_pop_out", bus.outstanding_o, 2);
    rv = 0; ym = 0;
    for (int i = 0; i < 500; i++) begin
      for (int s = 0; s < N; s++)
        if (!pend[s] && $urandom_range(0, 2) == 0) begin pend[s] = 1; dat[s] = {$urandom, $urandom}; end
      rdy = $urandom_range(0, 3) != 0;
      rv = q.size() > 0 && $urandom_range(0, 1) == 1;
      ym = rv ? N'($urandom) : '0;
      rdat = {$urandom, $urandom};
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
